// File: rtl/mul_arbiter_pkg.sv
// Shared constants and types for the multiplier arbiter slice.
// REQ_* name the requester slots. MUL_* set the default operand widths and the burst cap.
// DIVMUL is 1/26 in Q14, used by normalize.
package mul_arbiter_pkg;

  localparam int REQ_NORM     = 0;
  localparam int REQ_ISR      = 1;
  localparam int REQ_DNN      = 2;
  localparam int MUL_NREQ     = 3;

  localparam int IBIT         = 26;
  localparam int MUL_ABIT     = 2 * IBIT - 13;
  localparam int MUL_BBIT     = IBIT - 4;
  localparam int MUL_MAXBURST = 64;

  localparam int DIVMUL       = 630;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mul_arbiter_smult_pipe.sv
// smult_pipe: two-stage registered signed multiplier with a one-hot tag sideband.
//   Stage 1 latches the operands and the tag. Stage 2 registers the full-width product.
//   The product register only loads on a valid op, so o_p holds between results.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset (clears the valids and data)
//   i_vld, i_tag     issue strobe and one-hot issuer tag
//   i_a, i_b         signed operands
//   o_dv             one-hot result valid, equal to the issuer tag
//   o_p              signed product, ABIT+BBIT wide
//   o_busy           either stage holds a valid op
module smult_pipe
  import mul_arbiter_pkg::*;
#(
  parameter int NREQ = MUL_NREQ,
  parameter int ABIT = MUL_ABIT,
  parameter int BBIT = MUL_BBIT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_vld,
  input  logic [NREQ-1:0]             i_tag,
  input  logic signed [ABIT-1:0]      i_a,
  input  logic signed [BBIT-1:0]      i_b,
  output logic [NREQ-1:0]             o_dv,
  output logic signed [ABIT+BBIT-1:0] o_p,
  output logic                        o_busy
);

  localparam int PW = ABIT + BBIT;

  logic                 r_s1_vld;
  logic [NREQ-1:0]      r_s1_tag;
  logic signed [ABIT-1:0] r_s1_a;
  logic signed [BBIT-1:0] r_s1_b;
  logic [NREQ-1:0]      r_s2_dv;
  logic signed [PW-1:0] r_p;
  logic signed [PW-1:0] w_ax;
  logic signed [PW-1:0] w_bx;

  assign w_ax = PW'(r_s1_a);
  assign w_bx = PW'(r_s1_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_tag <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s2_dv  <= '0;
      r_p      <= '0;
    end else begin
      r_s1_vld <= i_vld;
      r_s1_tag <= i_vld ? i_tag : '0;
      if (i_vld) begin
        r_s1_a <= i_a;
        r_s1_b <= i_b;
      end
      r_s2_dv <= r_s1_vld ? r_s1_tag : '0;
      if (r_s1_vld) r_p <= w_ax * w_bx;
    end
  end

  assign o_dv   = r_s2_dv;
  assign o_p    = r_p;
  assign o_busy = r_s1_vld | (|r_s2_dv);

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one pipelined signed multiplier among NREQ requesters.
//   Round-robin arbitration with burst lock and a MAXBURST forced release.
//   Each product goes back to its issuer with a one-hot dv_o tag.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   req_i, lock_i   per-requester request and burst-lock
//   a_i, b_i        packed per-requester operands (slice k = requester k)
//   gnt_o           registered one-hot grant (zero = no owner)
//   dv_o, p_o       tagged result valid and full-precision product
//   busy_o          the multiplier pipeline holds a valid op
//   ovr_o           one-cycle pulse when a lock is cut at MAXBURST
//
// state   | meaning
// ST_IDLE | no owner; grant the first requester at/after r_rr (no issue this cycle)
// ST_OWN  | r_own holds the grant; req issues; lock keeps the grant, otherwise it moves on
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int NREQ     = MUL_NREQ,
  parameter int ABIT     = MUL_ABIT,
  parameter int BBIT     = MUL_BBIT,
  parameter int MAXBURST = MUL_MAXBURST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        lock_i,
  input  logic [NREQ*ABIT-1:0]   a_i,
  input  logic [NREQ*BBIT-1:0]   b_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        dv_o,
  output logic [ABIT+BBIT-1:0]   p_o,
  output logic                   busy_o,
  output logic                   ovr_o
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(MAXBURST);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [PTRW-1:0] r_own;
  logic [PTRW-1:0] r_rr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovr;

  logic            w_issue;
  logic            w_lock_own;
  logic            w_cut;
  logic            w_move;
  logic [PTRW-1:0] w_own_inc;
  logic [PTRW-1:0] w_start;
  logic [NREQ-1:0] w_nxt_gnt;
  logic [PTRW-1:0] w_nxt_own;
  logic            w_found;
  logic [ABIT-1:0] w_a;
  logic [BBIT-1:0] w_b;

  assign w_issue    = |(req_i & r_gnt);
  assign w_lock_own = |(lock_i & r_gnt);
  assign w_cut      = w_issue & w_lock_own & (r_cnt == CW'(MAXBURST - 1));
  assign w_move     = ~w_lock_own | w_cut;
  assign w_own_inc  = (r_own == PTRW'(NREQ - 1)) ? '0 : r_own + 1'b1;
  // In IDLE, r_rr already equals the previous owner + 1, so both states search the same way.
  assign w_start    = (r_state == ST_OWN) ? w_own_inc : r_rr;

  // Rotating search: the first requester at/after w_start. The current owner comes last.
  always_comb begin
    w_nxt_gnt = '0;
    w_nxt_own = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      logic [PTRW-1:0] idx;
      idx = PTRW'((int'(w_start) + i) % NREQ);
      if (!w_found && req_i[idx]) begin
        w_found        = 1'b1;
        w_nxt_own      = idx;
        w_nxt_gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gnt[k]) begin
        w_a = a_i[k*ABIT +: ABIT];
        w_b = b_i[k*BBIT +: BBIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_gnt   <= w_nxt_gnt;
            r_own   <= w_nxt_own;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_move) begin
            r_rr    <= w_own_inc;
            r_gnt   <= w_nxt_gnt;
            r_own   <= w_nxt_own;
            r_cnt   <= '0;
            r_ovr   <= w_cut;
            r_state <= w_found ? ST_OWN : ST_IDLE;
          end else if (w_issue) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  smult_pipe #(
    .NREQ (NREQ),
    .ABIT (ABIT),
    .BBIT (BBIT)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_issue),
    .i_tag  (r_gnt),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_dv   (dv_o),
    .o_p    (p_o),
    .o_busy (busy_o)
  );

  assign gnt_o = r_gnt;
  assign ovr_o = r_ovr;

endmodule
